// File: rtl/cell_pixel_mapper.sv
// Maps the raster position of each active pixel onto a cell grid and classifies it
// (outside grid, cell border, live cell, dead cell) from a double-buffered cell bank.
module cell_pixel_mapper #(
    parameter int GRID_W = 6,
    parameter int GRID_H = 6,
    parameter int BOX_W  = 80,
    parameter int BOX_H  = 80,
    parameter int BORDER = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       line_end,
    input  logic       pix_valid,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic       wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic [3:0] color_mode,
    output logic       mode_valid
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int XW    = $clog2(BOX_W);
    localparam int YW    = $clog2(BOX_H);
    localparam int CW    = $clog2(GRID_W + 1);
    localparam int RW    = $clog2(GRID_H + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(BOX_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(BOX_H - 1);
    localparam logic [XW-1:0] X_BORDER = XW'(BOX_W - BORDER);
    localparam logic [YW-1:0] Y_BORDER = YW'(BOX_H - BORDER);
    localparam logic [CW-1:0] COL_MAX  = CW'(GRID_W);
    localparam logic [RW-1:0] ROW_MAX  = RW'(GRID_H);
    localparam logic [5:0]    CELLS_L  = 6'(CELLS);

    logic [CELLS-1:0] bank0_r;
    logic [CELLS-1:0] bank1_r;
    logic             bank_sel_r;
    logic             pending_r;
    logic             swap_ack_r;

    logic [XW-1:0] x_in_box_r;
    logic [YW-1:0] y_in_box_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    logic       s1_valid_r;
    logic [5:0] s1_idx_r;
    logic       s1_oog_r;
    logic       s1_border_r;

    logic [3:0] color_mode_r;
    logic       mode_valid_r;

    logic             oog_s;
    logic             border_s;
    logic [5:0]       cell_idx_s;
    logic [CELLS-1:0] front_bits_s;
    logic             front_bit_s;
    logic             swap_now_s;

    // Position classification of the pixel currently on the input.
    always_comb begin
        oog_s      = 1'b0;
        border_s   = 1'b0;
        cell_idx_s = 6'd0;
        oog_s    = (col_r >= COL_MAX) || (row_r >= ROW_MAX);
        border_s = (x_in_box_r >= X_BORDER) || (y_in_box_r >= Y_BORDER);
        if (oog_s) begin
            cell_idx_s = 6'd0;
        end else begin
            cell_idx_s = 6'(6'(row_r) * 6'(GRID_W) + 6'(col_r));
        end
    end

    // Front bank lookup for the cell held in stage 1, plus the swap decision.
    always_comb begin
        front_bits_s = '0;
        front_bit_s  = 1'b0;
        swap_now_s   = 1'b0;
        if (bank_sel_r) begin
            front_bits_s = bank1_r;
        end else begin
            front_bits_s = bank0_r;
        end
        front_bit_s = front_bits_s[s1_idx_r];
        swap_now_s  = frame_start && (pending_r || swap_req);
    end

    // Raster position counters; frame_start wins over line_end, which wins over pix_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_in_box_r <= '0;
            y_in_box_r <= '0;
            col_r      <= '0;
            row_r      <= '0;
        end else if (frame_start) begin
            x_in_box_r <= '0;
            y_in_box_r <= '0;
            col_r      <= '0;
            row_r      <= '0;
        end else if (line_end) begin
            x_in_box_r <= '0;
            col_r      <= '0;
            if (y_in_box_r == Y_LAST) begin
                y_in_box_r <= '0;
                if (row_r != ROW_MAX) begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                y_in_box_r <= y_in_box_r + YW'(1);
            end
        end else if (pix_valid) begin
            if (x_in_box_r == X_LAST) begin
                x_in_box_r <= '0;
                if (col_r != COL_MAX) begin
                    col_r <= col_r + CW'(1);
                end
            end else begin
                x_in_box_r <= x_in_box_r + XW'(1);
            end
        end
    end

    // Two-stage classification pipeline; color_mode holds while no pixel emerges.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_idx_r     <= 6'd0;
            s1_oog_r     <= 1'b0;
            s1_border_r  <= 1'b0;
            color_mode_r <= 4'b0000;
            mode_valid_r <= 1'b0;
        end else begin
            s1_valid_r   <= pix_valid;
            mode_valid_r <= s1_valid_r;
            if (pix_valid) begin
                s1_idx_r    <= cell_idx_s;
                s1_oog_r    <= oog_s;
                s1_border_r <= border_s;
            end
            if (s1_valid_r) begin
                if (s1_oog_r) begin
                    color_mode_r <= 4'b1111;
                end else if (s1_border_r) begin
                    color_mode_r <= 4'b0001;
                end else if (front_bit_s) begin
                    color_mode_r <= 4'b0010;
                end else begin
                    color_mode_r <= 4'b0000;
                end
            end
        end
    end

    // Bank storage and swap control; a write in the swap cycle lands in the outgoing back bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank0_r    <= '0;
            bank1_r    <= '0;
            bank_sel_r <= 1'b0;
            pending_r  <= 1'b0;
            swap_ack_r <= 1'b0;
        end else begin
            if (wr_en && (wr_addr < CELLS_L)) begin
                if (bank_sel_r) begin
                    bank0_r[wr_addr] <= wr_data;
                end else begin
                    bank1_r[wr_addr] <= wr_data;
                end
            end
            if (swap_now_s) begin
                bank_sel_r <= ~bank_sel_r;
                pending_r  <= 1'b0;
                swap_ack_r <= 1'b1;
            end else begin
                swap_ack_r <= 1'b0;
                if (swap_req) begin
                    pending_r <= 1'b1;
                end
            end
        end
    end

    assign swap_ack   = swap_ack_r;
    assign color_mode = color_mode_r;
    assign mode_valid = mode_valid_r;

endmodule

// File: tb/tb_cell_pixel_mapper.sv
// Directed testbench for cell_pixel_mapper: raster lines are driven and each emerging
// color_mode is captured in order, then checked against hand-computed classes.
module tb_cell_pixel_mapper;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       line_end;
    logic       pix_valid;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [3:0] color_mode;
    logic       mode_valid;

    int vec_cnt;
    int err_cnt;
    int ack_cnt;
    logic [3:0] cap[$];

    cell_pixel_mapper dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .line_end   (line_end),
        .pix_valid  (pix_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .color_mode (color_mode),
        .mode_valid (mode_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every qualified output and count swap acknowledges.
    always @(negedge clk) begin
        if (mode_valid) cap.push_back(color_mode);
        if (swap_ack) ack_cnt = ack_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int n);
        cap.delete();
        pix_valid = 1'b1;
        repeat (n) step();
        pix_valid = 1'b0;
        line_end  = 1'b1;
        step();
        line_end = 1'b0;
        step();
        step();
    endtask

    task automatic blank_lines(input int n);
        repeat (n) begin
            line_end = 1'b1;
            step();
            line_end = 1'b0;
        end
    endtask

    task automatic pulse_frame(input logic sreq, input logic we, input logic [5:0] wa,
                               input logic wd);
        frame_start = 1'b1;
        swap_req    = sreq;
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        step();
        frame_start = 1'b0;
        swap_req    = 1'b0;
        wr_en       = 1'b0;
    endtask

    task automatic write_cell(input logic [5:0] wa, input logic wd);
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_cap(input string name, input int idx, input logic [3:0] exp);
        logic [3:0] got;
        got = (idx < cap.size()) ? cap[idx] : 4'bxxxx;
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: pixel %0d got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vec_cnt++;
        if (mode_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mode_valid: got %b expected 0", mode_valid);
        end
        vec_cnt++;
        if (color_mode !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_color_mode: got %b expected 0000", color_mode);
        end
        vec_cnt++;
        if (swap_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_swap_ack: got %b expected 0", swap_ack);
        end
    endtask

    task automatic test_first_line();
        int n_oog;
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        drive_line(480);
        vec_cnt++;
        if (cap.size() != 480) begin
            err_cnt++;
            $display("FAIL line_count: got %0d expected 480", cap.size());
        end
        check_cap("first_pixel0", 0, 4'b0000);
        check_cap("first_pixel76", 76, 4'b0000);
        check_cap("first_pixel77", 77, 4'b0001);
        check_cap("first_pixel479", 479, 4'b0001);
        n_oog = 0;
        foreach (cap[i]) if (cap[i] === 4'b1111) n_oog++;
        vec_cnt++;
        if (n_oog != 0) begin
            err_cnt++;
            $display("FAIL first_no_oog: got %0d oog pixels expected 0", n_oog);
        end
    endtask

    task automatic test_swap();
        write_cell(6'd7, 1'b1);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        vec_cnt++;
        if (swap_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL swap_ack_pulse: got %b expected 1", swap_ack);
        end
        step();
        vec_cnt++;
        if (swap_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL swap_ack_single: got %b expected 0", swap_ack);
        end
        blank_lines(80);
        drive_line(161);
        check_cap("swap_pixel79", 79, 4'b0001);
        check_cap("swap_cell7", 80, 4'b0010);
        check_cap("swap_cell8", 160, 4'b0000);
    endtask

    task automatic test_out_of_grid();
        int n_oog;
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        drive_line(520);
        check_cap("oog_pixel479", 479, 4'b0001);
        check_cap("oog_pixel480", 480, 4'b1111);
        check_cap("oog_pixel519", 519, 4'b1111);
        blank_lines(479);
        drive_line(10);
        n_oog = 0;
        foreach (cap[i]) if (cap[i] === 4'b1111) n_oog++;
        vec_cnt++;
        if (n_oog != 10) begin
            err_cnt++;
            $display("FAIL oog_line480: got %0d oog pixels expected 10", n_oog);
        end
    endtask

    task automatic test_multi_swap();
        write_cell(6'd8, 1'b1);
        ack_cnt = 0;
        repeat (3) begin
            swap_req = 1'b1;
            step();
            swap_req = 1'b0;
            step();
        end
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        repeat (4) step();
        vec_cnt++;
        if (ack_cnt != 1) begin
            err_cnt++;
            $display("FAIL multi_swap_acks: got %0d expected 1", ack_cnt);
        end
        blank_lines(80);
        drive_line(161);
        check_cap("multi_cell7", 80, 4'b0000);
        check_cap("multi_cell8", 160, 4'b0010);
    endtask

    task automatic test_swap_write();
        write_cell(6'd40, 1'b1);
        pulse_frame(1'b1, 1'b1, 6'd0, 1'b1);
        vec_cnt++;
        if (swap_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL coincident_swap_ack: got %b expected 1", swap_ack);
        end
        drive_line(330);
        check_cap("swapwr_cell0", 0, 4'b0010);
        check_cap("swapwr_cell4", 320, 4'b0000);
        blank_lines(79);
        drive_line(81);
        check_cap("swapwr_cell7", 80, 4'b0010);
    endtask

    task automatic test_mid_reset();
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        blank_lines(50);
        pix_valid = 1'b1;
        repeat (200) step();
        reset = 1'b1;
        step();
        vec_cnt++;
        if (mode_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_valid: got %b expected 0", mode_valid);
        end
        reset     = 1'b0;
        pix_valid = 1'b0;
        step();
        vec_cnt++;
        if (mode_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL postreset_valid: got %b expected 0", mode_valid);
        end
        pulse_frame(1'b0, 1'b0, 6'd0, 1'b0);
        drive_line(5);
        check_cap("midreset_bank0_cell0", 0, 4'b0000);
        pulse_frame(1'b1, 1'b0, 6'd0, 1'b0);
        vec_cnt++;
        if (swap_ack !== 1'b1) begin
            err_cnt++;
            $display("FAIL midreset_swap_ack: got %b expected 1", swap_ack);
        end
        drive_line(5);
        check_cap("midreset_bank1_cell0", 0, 4'b0000);
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        ack_cnt     = 0;
        reset       = 1'b1;
        frame_start = 1'b0;
        line_end    = 1'b0;
        pix_valid   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 6'd0;
        wr_data     = 1'b0;
        swap_req    = 1'b0;
        step();
        test_reset();
        test_first_line();
        test_swap();
        test_out_of_grid();
        test_multi_swap();
        test_swap_write();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
